// File: rtl/std_pkg.sv
// Shared definitions for the std_* block library: skid-buffer FSM state encoding.
package std_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        BUSY  = 2'b01,
        FULL  = 2'b10
    } skid_state_e;

endpackage

// File: rtl/std_skid_buffer_if.sv
// Valid/ready handshake bundle for std_skid_buffer: upstream (s_*) and downstream (m_*) sides.
interface std_skid_buffer_if #(
    parameter int DATA_WIDTH = 1
);
    logic                  s_valid;
    logic                  s_ready;
    logic [DATA_WIDTH-1:0] s_data;
    logic                  m_valid;
    logic                  m_ready;
    logic [DATA_WIDTH-1:0] m_data;

    // The buffer sits on the slave side; the surrounding logic drives it as master.
    modport slave  (input  s_valid, s_data, m_ready, output s_ready, m_valid, m_data);
    modport master (output s_valid, s_data, m_ready, input  s_ready, m_valid, m_data);
endinterface

// File: rtl/std_dffe.sv
// Enable-gated DFF without reset; holds its value whenever en is low.
module std_dffe #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    logic [WIDTH-1:0] data_d;
    logic [WIDTH-1:0] data_q;

    always_comb begin
        data_d = data_q;
        if (en) data_d = d;
    end

    always_ff @(posedge clk) begin
        data_q <= data_d;
    end

    assign q = data_q;
endmodule

// File: rtl/std_skid_buffer.sv
// Two-entry skid buffer (main + skid) with fully registered s_ready / m_valid.
// Optional synchronous flush port enabled by defining STD_SKID_BUFFER_FLUSH_EN.
module std_skid_buffer
    import std_pkg::*;
#(
    parameter int DATA_WIDTH = 1
) (
    input  logic clk,
    input  logic reset,
`ifdef STD_SKID_BUFFER_FLUSH_EN
    input  logic flush,
`endif
    std_skid_buffer_if.slave bus
);
    skid_state_e           state_q, state_d;
    logic                  up_xfer, dn_xfer;
    logic                  main_en, skid_en, main_from_skid;
    logic [DATA_WIDTH-1:0] main_d, main_q, skid_q;
    logic                  drop;

`ifdef STD_SKID_BUFFER_FLUSH_EN
    assign drop = reset | flush;
`else
    assign drop = reset;
`endif

    assign bus.s_ready = (state_q != FULL);
    assign bus.m_valid = (state_q != EMPTY);
    assign bus.m_data  = main_q;

    assign up_xfer = bus.s_valid & bus.s_ready;
    assign dn_xfer = bus.m_valid & bus.m_ready;

    always_comb begin
        state_d        = state_q;
        main_en        = 1'b0;
        skid_en        = 1'b0;
        main_from_skid = 1'b0;
        case (state_q)
            EMPTY: begin
                if (up_xfer) begin
                    main_en = 1'b1;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (up_xfer && dn_xfer) begin
                    main_en = 1'b1;
                end else if (up_xfer) begin
                    skid_en = 1'b1;
                    state_d = FULL;
                end else if (dn_xfer) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                if (dn_xfer) begin
                    main_en        = 1'b1;
                    main_from_skid = 1'b1;
                    state_d        = BUSY;
                end
            end
            default: state_d = EMPTY;
        endcase
        // Reset/flush discard everything, so the data registers need not load either.
        if (drop) begin
            state_d = EMPTY;
            main_en = 1'b0;
            skid_en = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) state_q <= EMPTY;
        else       state_q <= state_d;
    end

    assign main_d = main_from_skid ? skid_q : bus.s_data;

    std_dffe #(.WIDTH(DATA_WIDTH)) u_main (
        .clk (clk),
        .en  (main_en),
        .d   (main_d),
        .q   (main_q)
    );

    std_dffe #(.WIDTH(DATA_WIDTH)) u_skid (
        .clk (clk),
        .en  (skid_en),
        .d   (bus.s_data),
        .q   (skid_q)
    );
endmodule

// File: doc/std_skid_buffer.md
STD_SKID_BUFFER -- requirements
Module: std_skid_buffer

Interface
REQ-001 The parameter DATA_WIDTH SHALL default to 1 and set the payload width in bits.
REQ-002 Port clk SHALL be an input, 1 bit wide, and is the single clock; all state updates on its rising edge.
REQ-003 Port reset SHALL be an input, 1 bit wide, and is the synchronous, active-high reset.
REQ-004 Port s_valid SHALL be an input, 1 bit wide, and indicates the upstream producer has valid data.
REQ-005 Port s_ready SHALL be an output, 1 bit wide, and indicates the buffer can accept upstream data.
REQ-006 Port s_data SHALL be an input, DATA_WIDTH bits wide, and carries the upstream payload.
REQ-007 Port m_valid SHALL be an output, 1 bit wide, and indicates the buffer presents valid data downstream.
REQ-008 Port m_ready SHALL be an input, 1 bit wide, and indicates the downstream consumer accepts data.
REQ-009 Port m_data SHALL be an output, DATA_WIDTH bits wide, and carries the downstream payload.
REQ-010 When STD_SKID_BUFFER_FLUSH_EN is defined, the block SHALL have an input port flush, 1 bit wide, that provides a synchronous discard of all held data.

Function
REQ-011 The block SHALL hold two entries, main and skid, tracked by a three-state FSM with states EMPTY, BUSY (main only) and FULL (main and skid).
REQ-012 An upstream transfer SHALL occur on a cycle where s_valid and s_ready are both high; a downstream transfer SHALL occur on a cycle where m_valid and m_ready are both high.
REQ-013 s_ready SHALL equal (state != FULL) and m_valid SHALL equal (state != EMPTY), so both are decoded from registered state only, with no combinational path from any input.
REQ-014 m_data SHALL always drive the main register.
REQ-015 In EMPTY, an upstream transfer SHALL load main and go to BUSY; otherwise the FSM SHALL stay in EMPTY.
REQ-016 In BUSY, simultaneous upstream and downstream transfers SHALL load main and stay in BUSY.
REQ-017 In BUSY, an upstream transfer without a downstream transfer SHALL load skid and go to FULL.
REQ-018 In BUSY, a downstream transfer without an upstream transfer SHALL go to EMPTY.
REQ-019 In FULL, a downstream transfer SHALL copy skid into main and go to BUSY; otherwise the FSM SHALL stay in FULL.
REQ-020 Latency from an upstream transfer to m_valid for that data SHALL be exactly 1 cycle.
REQ-021 Sustained throughput SHALL be 1 transfer per cycle when m_ready is held high.
REQ-022 Data SHALL be delivered in order with no loss or duplication.
REQ-023 While m_valid is high and m_ready is low, m_data SHALL remain stable.
REQ-024 Registers SHALL not load on cycles where no transfer requires it, for power.

Reset
REQ-025 When reset is high at a clock edge, the next state SHALL be EMPTY, so that after reset m_valid=0 and s_ready=1.
REQ-026 reset SHALL take precedence over all other inputs.
REQ-027 s_valid asserted during the reset cycle SHALL be discarded.
REQ-028 Data registers SHALL not require reset, and their content SHALL be don't-care while m_valid=0.
REQ-029 Reset asserted mid-operation SHALL drop all held entries within one cycle.

Configuration
REQ-030 With STD_SKID_BUFFER_FLUSH_EN defined, flush high at a clock edge SHALL force the next state to EMPTY and discard main, skid and any same-cycle s_data.
REQ-031 Flush priority SHALL be below reset and above all transfers, and a downstream transfer on the flush cycle SHALL still count as consumed.
REQ-032 Without STD_SKID_BUFFER_FLUSH_EN, the flush port and its logic SHALL be absent, and behaviour SHALL otherwise be identical.

Structure
REQ-033 The FSM state encoding (EMPTY=2'b00, BUSY=2'b01, FULL=2'b10) SHALL be placed in the shared package std_pkg.
REQ-034 Main and skid storage SHALL each be implemented by instantiating the sub-module std_dffe (enable-gated DFF, DATA_WIDTH wide).

Verification
REQ-035 The bench SHALL check reset: with reset=1 for 2 cycles and s_valid=1, s_data=0x5, the first cycle after reset SHALL show m_valid=0 and s_ready=1.
REQ-036 The bench SHALL check streaming: with m_ready=1 and s_data=1,2,3,4 on consecutive cycles, m_data SHALL be 1,2,3,4 one cycle later with m_valid continuously high.
REQ-037 The bench SHALL check backpressure: with m_ready=0 and s_data=0xA then 0xB, the FSM SHALL reach FULL, s_ready=0, and m_data SHALL hold 0xA; when m_ready is raised, the outputs SHALL be 0xA then 0xB, after which s_ready=1.
REQ-038 The bench SHALL check simultaneous operation: in BUSY holding 0x3, s_valid=1 with s_data=0x4 and m_ready=1 SHALL keep the FSM in BUSY with m_data=0x4 on the next cycle.
REQ-039 The bench SHALL check drain: in FULL with s_valid=0 and m_ready=1 for 2 cycles, the FSM SHALL pass through BUSY then EMPTY, and m_valid SHALL read 1, 1, 0.
REQ-040 With STD_SKID_BUFFER_FLUSH_EN defined, the bench SHALL check flush: in FULL, flush=1 together with s_valid=1 SHALL give m_valid=0 and s_ready=1 on the next cycle, with the s_data of that cycle dropped.
